// File: rtl/instruction_fetcher.sv
// ============================================================================
//  Module   : instruction_fetcher
//  Purpose  : Per-core instruction fetch unit with optional direct-mapped
//             instruction cache (enabled by INSTRUCTION_FETCHER_ICACHE_EN).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetcher #(
    parameter int PROGRAM_MEM_ADDR_BITS = 8,
    parameter int PROGRAM_MEM_DATA_BITS = 16,
    parameter int ICACHE_LINES          = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [2:0]                       core_state,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
    output logic                             mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
    input  logic                             mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
    output logic [2:0]                       fetcher_state,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
    output logic [15:0]                      hit_count,
    output logic [15:0]                      miss_count
);

    localparam logic [2:0] CORE_FETCH  = 3'b001;
    localparam logic [2:0] CORE_DECODE = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE     = 3'b000,
        S_FETCHING = 3'b001,
        S_FETCHED  = 3'b010
    } state_e;

    if (ICACHE_LINES < 2 || (ICACHE_LINES & (ICACHE_LINES - 1)) != 0) begin : g_bad_lines
        $error("ICACHE_LINES must be a power of two >= 2");
    end

    state_e                             state_q, state_d;
    logic                               mem_read_valid_q, mem_read_valid_d;
    logic [PROGRAM_MEM_ADDR_BITS-1:0]   mem_read_address_q, mem_read_address_d;
    logic [PROGRAM_MEM_DATA_BITS-1:0]   instruction_q, instruction_d;
    logic [15:0]                        miss_count_q, miss_count_d;
    logic                               miss_inc;

`ifdef INSTRUCTION_FETCHER_ICACHE_EN
    localparam int IDX = $clog2(ICACHE_LINES);
    localparam int TAG = PROGRAM_MEM_ADDR_BITS - IDX;

    logic [ICACHE_LINES-1:0]            line_valid_q;
    logic [TAG-1:0]                     line_tag_q  [ICACHE_LINES];
    logic [PROGRAM_MEM_DATA_BITS-1:0]   line_data_q [ICACHE_LINES];
    logic [IDX-1:0]                     rd_idx;
    logic [IDX-1:0]                     fill_idx;
    logic                               cache_hit;
    logic                               fill;
    logic                               hit_inc;
    logic [15:0]                        hit_count_q, hit_count_d;

    assign rd_idx    = current_pc[IDX-1:0];
    assign fill_idx  = mem_read_address_q[IDX-1:0];
    assign cache_hit = line_valid_q[rd_idx] &&
                       (line_tag_q[rd_idx] == current_pc[PROGRAM_MEM_ADDR_BITS-1:IDX]);
    assign fill      = (state_q == S_FETCHING) && mem_read_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_valid_q <= '0;
            hit_count_q  <= '0;
        end else begin
            if (fill) line_valid_q[fill_idx] <= 1'b1;
            hit_count_q <= hit_count_d;
        end
    end

    // Tag/data need no reset: they are only observed through a set valid bit.
    always_ff @(posedge clk) begin
        if (fill) begin
            line_tag_q[fill_idx]  <= mem_read_address_q[PROGRAM_MEM_ADDR_BITS-1:IDX];
            line_data_q[fill_idx] <= mem_read_data;
        end
    end

    assign hit_count_d = (hit_inc && hit_count_q != 16'hFFFF) ? hit_count_q + 16'd1 : hit_count_q;
    assign hit_count   = hit_count_q;
`else
    assign hit_count = 16'd0;
`endif

    always_comb begin
        state_d            = state_q;
        mem_read_valid_d   = mem_read_valid_q;
        mem_read_address_d = mem_read_address_q;
        instruction_d      = instruction_q;
        miss_inc           = 1'b0;
`ifdef INSTRUCTION_FETCHER_ICACHE_EN
        hit_inc            = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (core_state == CORE_FETCH) begin
                    mem_read_valid_d   = 1'b1;
                    mem_read_address_d = current_pc;
                    state_d            = S_FETCHING;
                    miss_inc           = 1'b1;
`ifdef INSTRUCTION_FETCHER_ICACHE_EN
                    if (cache_hit) begin
                        mem_read_valid_d   = 1'b0;
                        mem_read_address_d = mem_read_address_q;
                        instruction_d      = line_data_q[rd_idx];
                        state_d            = S_FETCHED;
                        miss_inc           = 1'b0;
                        hit_inc            = 1'b1;
                    end
`endif
                end
            end
            S_FETCHING: begin
                if (mem_read_ready) begin
                    instruction_d    = mem_read_data;
                    mem_read_valid_d = 1'b0;
                    state_d          = S_FETCHED;
                end
            end
            S_FETCHED: begin
                if (core_state == CORE_DECODE) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign miss_count_d = (miss_inc && miss_count_q != 16'hFFFF) ? miss_count_q + 16'd1 : miss_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q            <= S_IDLE;
            mem_read_valid_q   <= 1'b0;
            mem_read_address_q <= '0;
            instruction_q      <= '0;
            miss_count_q       <= '0;
        end else begin
            state_q            <= state_d;
            mem_read_valid_q   <= mem_read_valid_d;
            mem_read_address_q <= mem_read_address_d;
            instruction_q      <= instruction_d;
            miss_count_q       <= miss_count_d;
        end
    end

    assign fetcher_state    = state_q;
    assign mem_read_valid   = mem_read_valid_q;
    assign mem_read_address = mem_read_address_q;
    assign instruction      = instruction_q;
    assign miss_count       = miss_count_q;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetcher.sv
// ============================================================================
//  Module   : tb_instruction_fetcher
//  Purpose  : Randomized self-checking bench for instruction_fetcher against a
//             transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetcher;

    localparam int         LINES    = 4;
    localparam logic [2:0] CS_FETCH = 3'b001;
    localparam logic [2:0] CS_DEC   = 3'b010;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  core_state;
    logic [7:0]  current_pc;
    logic        mem_read_valid;
    logic [7:0]  mem_read_address;
    logic        mem_read_ready;
    logic [15:0] mem_read_data;
    logic [2:0]  fetcher_state;
    logic [15:0] instruction;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    instruction_fetcher #(
        .PROGRAM_MEM_ADDR_BITS(8),
        .PROGRAM_MEM_DATA_BITS(16),
        .ICACHE_LINES(LINES)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .core_state       (core_state),
        .current_pc       (current_pc),
        .mem_read_valid   (mem_read_valid),
        .mem_read_address (mem_read_address),
        .mem_read_ready   (mem_read_ready),
        .mem_read_data    (mem_read_data),
        .fetcher_state    (fetcher_state),
        .instruction      (instruction),
        .hit_count        (hit_count),
        .miss_count       (miss_count)
    );

    always #5 clk = ~clk;

    // Reference model: expected outputs plus a cache keyed by line holding full PCs.
    logic [2:0]  exp_state;
    logic        exp_valid;
    logic [7:0]  exp_addr;
    logic [15:0] exp_instr;
    logic [15:0] exp_hit;
    logic [15:0] exp_miss;
    logic        mvalid [LINES];
    logic [7:0]  mpc    [LINES];
    logic [15:0] memimg [256];

    int  n_vec  = 0;
    int  n_fail = 0;
    bit  chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("state",       {29'd0, fetcher_state}, {29'd0, exp_state});
            check("mem_valid",   {31'd0, mem_read_valid}, {31'd0, exp_valid});
            check("mem_addr",    {24'd0, mem_read_address}, {24'd0, exp_addr});
            check("instruction", {16'd0, instruction}, {16'd0, exp_instr});
            check("hit_count",   {16'd0, hit_count}, {16'd0, exp_hit});
            check("miss_count",  {16'd0, miss_count}, {16'd0, exp_miss});
        end
    end

    function automatic logic [15:0] sat(input logic [15:0] x);
        return (x == 16'hFFFF) ? x : x + 16'd1;
    endfunction

    function automatic logic [2:0] idle_cs();
        logic [2:0] v;
        v = 3'($urandom_range(0, 6));
        if (v >= 3'd1) v = v + 3'd1;
        return v;
    endfunction

    task automatic model_reset();
        exp_state = 3'b000; exp_valid = 1'b0; exp_addr = 8'h00;
        exp_instr = 16'h0;  exp_hit = 16'h0;  exp_miss = 16'h0;
        for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        core_state = idle_cs();
    endtask

    // One full fetch: FETCH request, memory response after lat cycles (on a
    // miss), hold cycles with FETCH kept asserted, then DECODE back to IDLE.
    task automatic do_fetch(input logic [7:0] pc, input int lat, input int hold);
        int   idx;
        logic hit;
        idx = int'(pc) % LINES;
`ifdef INSTRUCTION_FETCHER_ICACHE_EN
        hit = mvalid[idx] && (mpc[idx] == pc);
`else
        hit = 1'b0;
`endif
        @(negedge clk);
        core_state     = CS_FETCH;
        current_pc     = pc;
        mem_read_ready = 1'($urandom);
        mem_read_data  = 16'($urandom);
        if (hit) begin
            exp_state = 3'b010;
            exp_instr = memimg[pc];
            exp_hit   = sat(exp_hit);
        end else begin
            exp_state = 3'b001;
            exp_valid = 1'b1;
            exp_addr  = pc;
            exp_miss  = sat(exp_miss);
            for (int k = 1; k <= lat; k++) begin
                @(negedge clk);
                current_pc = 8'($urandom);
                core_state = 3'($urandom);
                if (k == lat) begin
                    mem_read_ready = 1'b1;
                    mem_read_data  = memimg[pc];
                    exp_state      = 3'b010;
                    exp_valid      = 1'b0;
                    exp_instr      = memimg[pc];
                    mvalid[idx]    = 1'b1;
                    mpc[idx]       = pc;
                end else begin
                    mem_read_ready = 1'b0;
                    mem_read_data  = 16'($urandom);
                end
            end
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            core_state     = CS_FETCH;
            current_pc     = 8'($urandom);
            mem_read_ready = 1'($urandom);
            mem_read_data  = 16'($urandom);
        end
        @(negedge clk);
        core_state     = CS_DEC;
        mem_read_ready = 1'($urandom);
        mem_read_data  = 16'($urandom);
        exp_state      = 3'b000;
        @(negedge clk);
        core_state     = idle_cs();
        mem_read_ready = 1'($urandom);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) memimg[i] = 16'($urandom);
        reset = 1'b1; core_state = 3'b000; current_pc = 8'h00;
        mem_read_ready = 1'b0; mem_read_data = 16'h0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_state",  {29'd0, fetcher_state}, 32'h0);
        check("rst_valid",  {31'd0, mem_read_valid}, 32'h0);
        check("rst_instr",  {16'd0, instruction}, 32'h0);
        reset = 1'b0;
        chk_en = 1'b1;

        // Reset while a miss is stalled; the late response must be ignored.
        @(negedge clk);
        core_state = CS_FETCH; current_pc = 8'h10; mem_read_ready = 1'b0;
        exp_state = 3'b001; exp_valid = 1'b1; exp_addr = 8'h10; exp_miss = 16'd1;
        @(negedge clk);
        core_state = 3'b000;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        check("async_rst_valid", {31'd0, mem_read_valid}, 32'h0);
        check("async_rst_state", {29'd0, fetcher_state}, 32'h0);
        check("async_rst_miss",  {16'd0, miss_count}, 32'h0);
        check("async_rst_addr",  {24'd0, mem_read_address}, 32'h0);
        @(negedge clk);
        reset = 1'b0; mem_read_ready = 1'b1; mem_read_data = 16'hBEEF;
        @(negedge clk);
        mem_read_ready = 1'b0;
        @(negedge clk);

        // Cold miss with 2-cycle memory, held 5 cycles in FETCHED, then refetch.
        memimg[8'h05] = 16'h3A5C;
        do_fetch(8'h05, 2, 5);
        check("cold_instr", {16'd0, instruction}, 32'h3A5C);
        check("cold_miss",  {16'd0, miss_count}, 32'd1);
        do_fetch(8'h05, 2, 0);
        check("refetch_instr", {16'd0, instruction}, 32'h3A5C);
`ifdef INSTRUCTION_FETCHER_ICACHE_EN
        check("refetch_hit",  {16'd0, hit_count}, 32'd1);
        check("refetch_miss", {16'd0, miss_count}, 32'd1);
`else
        check("refetch_hit",  {16'd0, hit_count}, 32'd0);
        check("refetch_miss", {16'd0, miss_count}, 32'd2);
`endif

        // Conflicting lines evict each other.
        do_reset();
        memimg[8'h01] = 16'h1111;
        memimg[8'h05] = 16'h5555;
        do_fetch(8'h01, 1, 0);
        do_fetch(8'h05, 2, 1);
        do_fetch(8'h01, 3, 0);
        check("conflict_miss",  {16'd0, miss_count}, 32'd3);
        check("conflict_hit",   {16'd0, hit_count}, 32'd0);
        check("conflict_instr", {16'd0, instruction}, 32'h1111);

        for (int n = 0; n < 300; n++)
            do_fetch(8'($urandom_range(0, 15)), $urandom_range(1, 4), $urandom_range(0, 3));

        // Saturation of the miss counter.
        @(negedge clk);
        force dut.miss_count_q = 16'hFFFE;
        exp_miss = 16'hFFFE;
        #1;
        release dut.miss_count_q;
        do_fetch(8'h80, 1, 0);
        do_fetch(8'h84, 2, 0);
        check("sat_miss_1", {16'd0, miss_count}, 32'hFFFF);
        do_fetch(8'h88, 1, 0);
        check("sat_miss_2", {16'd0, miss_count}, 32'hFFFF);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
